// File: rtl/branch_scan_unit_pkg.sv
// Shared definitions for the branch-resolution scanner:
// instruction opcodes, scan FSM states and scan directions.
package branch_scan_unit_pkg;

  typedef enum logic [3:0] {
    NOP,
    INC,
    DEC,
    MVL,
    MVR,
    OUTP,
    INP,
    CBF,
    CBB
  } op_code;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE,
    ERR
  } scan_state_e;

  localparam logic SCAN_FWD  = 1'b0;
  localparam logic SCAN_BACK = 1'b1;

endpackage

// File: rtl/branch_depth_counter.sv
// Bracket nesting depth counter with overflow and
// look-ahead zero detection for the scan FSM.
module branch_depth_counter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               is_zero_next_o,
  output logic               at_max_o
);

  localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);

  logic [DEPTH_W-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (load_i)
      depth_d = D_ONE;
    else if (inc_i)
      depth_d = depth_q + D_ONE;
    else if (dec_i)
      depth_d = depth_q - D_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset)
      depth_q <= '0;
    else
      depth_q <= depth_d;
  end

  assign depth_o        = depth_q;
  assign is_zero_next_o = dec_i && (depth_q == D_ONE);
  assign at_max_o       = &depth_q;

endmodule

// File: rtl/branch_scan_unit.sv
// Walks program memory from a taken CBF/CBB to find the
// matching bracket, one outstanding read at a time.
module branch_scan_unit
  import branch_scan_unit_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int DEPTH_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_dir,
  input  logic [PC_W-1:0] req_pc,
  output logic            req_ready,
  output logic            done,
  output logic            error,
  output logic [PC_W-1:0] target_pc,
  output logic            mem_rd_en,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_rd_valid,
  input  op_code          mem_rd_data
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  scan_state_e     state_q, state_d;
  logic [PC_W-1:0] cursor_q, cursor_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            dir_q, dir_d;

  op_code          open_op, close_op;
  logic            rd_hit, is_open, is_close;
  logic            at_edge, req_edge, accept;
  logic            zero_nx, at_max;
  logic [DEPTH_W-1:0] unused_depth;

  assign open_op  = (dir_q == SCAN_FWD) ? CBF : CBB;
  assign close_op = (dir_q == SCAN_FWD) ? CBB : CBF;
  assign rd_hit   = mem_rd_valid && (state_q == WAIT);
  assign is_open  = rd_hit && (mem_rd_data == open_op);
  assign is_close = rd_hit && (mem_rd_data == close_op);
  assign accept   = req_valid && (state_q == IDLE);

  // Stepping past either end of the address space is a failed scan
  assign at_edge  = (dir_q == SCAN_FWD) ? &cursor_q : ~|cursor_q;
  assign req_edge = (req_dir == SCAN_FWD) ? &req_pc : ~|req_pc;

  branch_depth_counter #(
    .DEPTH_W(DEPTH_W)
  ) u_depth (
    .clock         (clock),
    .reset         (reset),
    .load_i        (accept),
    .inc_i         (is_open && !at_max),
    .dec_i         (is_close),
    .depth_o       (unused_depth),
    .is_zero_next_o(zero_nx),
    .at_max_o      (at_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      target_q <= '0;
      dir_q    <= SCAN_FWD;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      target_q <= target_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    target_d = target_q;
    dir_d    = dir_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          dir_d = req_dir;
          if (req_edge) begin
            state_d = ERR;
          end else begin
            cursor_d = (req_dir == SCAN_FWD) ? req_pc + PC_ONE
                                             : req_pc - PC_ONE;
            state_d  = FETCH;
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (mem_rd_valid) begin
          if (is_open && at_max) begin
            state_d = ERR;
          end else if (zero_nx) begin
            target_d = cursor_q;
            state_d  = DONE;
          end else if (at_edge) begin
            state_d = ERR;
          end else begin
            cursor_d = (dir_q == SCAN_FWD) ? cursor_q + PC_ONE
                                           : cursor_q - PC_ONE;
            state_d  = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    unique case (state_q)
      IDLE:  req_ready = 1'b1;
      FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = cursor_q;
      end
      DONE:  done = 1'b1;
      ERR: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  assign target_pc = target_q;

endmodule

// File: tb/tb_branch_scan_unit.sv
// Directed scoreboard bench for branch_scan_unit with a
// variable-latency program memory model.
module tb_branch_scan_unit;
  import branch_scan_unit_pkg::*;

  localparam int PC_W = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_dir;
  logic [PC_W-1:0] req_pc;
  logic            req_ready;
  logic            done;
  logic            error;
  logic [PC_W-1:0] target_pc;
  logic            mem_rd_en;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rd_valid;
  op_code          mem_rd_data;

  always #5 clock = ~clock;

  branch_scan_unit #(
    .PC_W   (PC_W),
    .DEPTH_W(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_dir     (req_dir),
    .req_pc      (req_pc),
    .req_ready   (req_ready),
    .done        (done),
    .error       (error),
    .target_pc   (target_pc),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data)
  );

  typedef struct {
    bit          err;
    logic [15:0] tgt;
    int          cyc;
  } exp_t;

  op_code mem [int];
  int     rd_cnt [int];
  int     rd_total;
  int     done_cnt;
  int     lat;
  bit     stray;
  int     passed;
  int     total;
  exp_t   sb [$];

  function automatic op_code rd(int a);
    return mem.exists(a) ? mem[a] : NOP;
  endfunction

  // Memory: a read strobe seen in cycle c returns data in cycle c+lat
  initial begin
    bit              pend;
    int              cnt;
    logic [PC_W-1:0] addr;
    pend = 1'b0;
    cnt = 0;
    addr = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data = NOP;
    forever begin
      @(posedge clock);
      #1;
      mem_rd_valid = 1'b0;
      if (done) done_cnt++;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          mem_rd_valid = 1'b1;
          mem_rd_data = rd(int'(addr));
        end
      end
      if (mem_rd_en) begin
        rd_total++;
        rd_cnt[int'(mem_addr)] = rd_cnt[int'(mem_addr)] + 1;
        pend = 1'b1;
        cnt = lat;
        addr = mem_addr;
        if (stray) begin
          mem_rd_valid = 1'b1;
          mem_rd_data = CBB;
        end
      end
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reads();
    rd_cnt.delete();
    rd_total = 0;
  endtask

  task automatic scan(string tag, bit dir, logic [15:0] pc,
                      bit err, logic [15:0] tgt, int cyc);
    exp_t e;
    int   k;
    sb.push_back('{err: err, tgt: tgt, cyc: cyc});
    req_valid = 1'b1;
    req_dir = dir;
    req_pc = pc;
    step();
    req_valid = 1'b0;
    k = 1;
    while (!done && k < 400) begin
      step();
      k++;
    end
    e = sb.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(k), 32'(e.cyc));
    check({tag, "_err"}, 32'(error), 32'(e.err));
    check({tag, "_tgt"}, 32'(target_pc), 32'(e.tgt));
    step();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int dc;
    reset = 1'b1;
    req_valid = 1'b0;
    req_dir = 1'b0;
    req_pc = '0;
    lat = 1;
    stray = 1'b0;
    step();
    step();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rden", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_tgt", 32'(target_pc), 32'd0);
    reset = 1'b0;
    step();

    mem[10] = CBF;
    mem[11] = INC;
    mem[12] = CBB;
    clear_reads();
    scan("fwd", 1'b0, 16'd10, 1'b0, 16'd12, 5);
    check("fwd_rd11", 32'(rd_cnt[11]), 32'd1);
    check("fwd_rd12", 32'(rd_cnt[12]), 32'd1);
    check("fwd_rdn", 32'(rd_total), 32'd2);

    mem[20] = CBF;
    mem[21] = CBF;
    mem[22] = CBB;
    mem[23] = CBB;
    clear_reads();
    scan("back", 1'b1, 16'd23, 1'b0, 16'd20, 7);
    check("back_rdn", 32'(rd_total), 32'd3);

    clear_reads();
    scan("wrap0", 1'b1, 16'd0, 1'b1, 16'd20, 1);
    check("wrap0_rdn", 32'(rd_total), 32'd0);

    clear_reads();
    scan("wrapF", 1'b0, 16'hFFFC, 1'b1, 16'd20, 7);
    check("wrapF_rdFFFF", 32'(rd_cnt[32'hFFFF]), 32'd1);
    check("wrapF_rdn", 32'(rd_total), 32'd3);

    mem[1] = CBF;
    mem[2] = CBF;
    mem[3] = CBF;
    clear_reads();
    scan("ovf", 1'b0, 16'd0, 1'b1, 16'd20, 7);
    check("ovf_rd3", 32'(rd_cnt[3]), 32'd1);
    check("ovf_rdn", 32'(rd_total), 32'd3);

    lat = 3;
    stray = 1'b1;
    clear_reads();
    scan("slow", 1'b0, 16'd10, 1'b0, 16'd12, 9);
    stray = 1'b0;
    check("slow_rd11", 32'(rd_cnt[11]), 32'd1);
    check("slow_rd12", 32'(rd_cnt[12]), 32'd1);
    check("slow_rdn", 32'(rd_total), 32'd2);

    mem[30] = CBF;
    mem[31] = CBB;
    req_valid = 1'b1;
    req_dir = 1'b0;
    req_pc = 16'd30;
    step();
    req_valid = 1'b0;
    step();
    check("mid_wait", 32'(dut.state_q), 32'(WAIT));
    dc = done_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_idle", 32'(dut.state_q), 32'(IDLE));
    check("mid_ready", 32'(req_ready), 32'd1);
    check("mid_done", 32'(done), 32'd0);
    repeat (6) step();
    check("mid_nodone", 32'(done_cnt), 32'(dc));
    check("mid_tgt", 32'(target_pc), 32'd0);

    lat = 1;
    scan("post", 1'b0, 16'd30, 1'b0, 16'd31, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
